id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection. It captures decoded operands and control from ID and presents them to EX. Its rs1/rs2/rd/RegWrite outputs drive the downstream forwarding unit. It issues a hold request to PC and IF/ID and injects bubbles for load-use, branch-flush and global-stall events.

Parameters:
XLEN, 32, datapath width
RAW, 5, register-address width
CNT_W, 16, width of load-use stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stall_i  in  1  global freeze (D-cache/I-cache miss); hold all state
flush_i  in  1  branch/jump redirect from EX; kill instruction entering EX
id_valid_i  in  1  ID holds a real instruction
id_pc_i  in  XLEN  instruction PC
id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
id_imm_i  in  XLEN  sign-extended immediate
id_rs1_i, id_rs2_i, id_rd_i  in  RAW  register addresses
id_uses_rs1_i, id_uses_rs2_i  in  1  instruction actually reads rs1/rs2
id_ctrl_i  in  CTRL_W  packed control (regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop[3:0])
ex_valid_o  out  1  EX holds a real instruction
ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN  registered copies
ex_rs1_o, ex_rs2_o, ex_rd_o  out  RAW  to forwarding unit and EX/MEM
ex_ctrl_o  out  CTRL_W  registered control
hazard_o  out  1  load-use hold request to PC and IF/ID
lu_stall_cnt_o  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (async, rst=1): all ex_* outputs = 0, ex_valid_o=0, lu_stall_cnt_o=0. hazard_o is then 0 because it derives from ex_valid_o. Reset mid-operation discards the in-flight instruction.
- Load-use detect (combinational from current EX state and ID inputs): lu = ex_valid_o & ex_ctrl_o.memread & (ex_rd_o!=0) & id_valid_i & ((id_uses_rs1_i & id_rs1_i==ex_rd_o) | (id_uses_rs2_i & id_rs2_i==ex_rd_o)).
- hazard_o = lu & ~flush_i. A flush kills the ID instruction, so no hold is requested.
- Per-edge update priority (highest first):
  1. stall_i=1: all registers hold; counter holds. hazard_o may assert but has no effect.
  2. flush_i=1: bubble.
  3. lu=1: bubble; counter += 1, saturating at 2^CNT_W-1.
  4. otherwise: load all ex_* from id_*; ex_valid_o = id_valid_i.
- Bubble: ex_valid_o=0; ex_ctrl_o, ex_rd_o, ex_rs1_o, ex_rs2_o all 0; data fields 0. With ex_rd_o=0 and regwrite=0, the forwarding unit cannot match.
- id_valid_i=0 on a normal load: control is still captured but gated. ex_ctrl_o is zeroed when id_valid_i=0, so an invalid slot never writes.
- Latency: 1 cycle ID→EX. Load-use costs exactly 1 bubble. The following cycle the load is in MEM, lu deasserts, and the dependent instruction enters EX with MEM/WB forwarding.
- x0 as load destination never raises hazard.
- stall_i and flush_i together: stall wins. The flush must be re-presented by its source after the stall drops.

Decomposition:
- Shared package core_pkg:
  - CTRL_W
  - ctrl_t packed struct field order (regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop)
  - ALUOP_* encodings
  - RAW/XLEN defaults
- One sub-module: load_use_detect (pure combinational lu equation), so it can be reused by a future dual-issue ID stage.
- Register and counter logic stay in id_ex_stage.

Test Plan:
- Reset: assert rst async mid-cycle with ex_valid_o=1 → all outputs 0 immediately, before the next clk edge; lu_stall_cnt_o=0.
- Normal flow: ID add x3,x1,x2 (rd=3, regwrite=1, valid=1) → next cycle ex_rd_o=3, ex_ctrl_o.regwrite=1, ex_valid_o=1, hazard_o=0.
- Load-use: EX holds lw x5 (memread=1, rd=5); ID presents add x6,x5,x7 (uses_rs1=1) → hazard_o=1 same cycle. Next edge: bubble (ex_valid_o=0, ex_rd_o=0), counter=1. Following cycle hazard_o=0 and add enters EX.
- No false hazard: EX lw x0, or EX lw x5 with ID using rs2=5 but uses_rs2=0 → hazard_o=0, no bubble, counter unchanged.
- Flush vs hazard: load-use condition true and flush_i=1 → hazard_o=0, bubble inserted, counter unchanged. stall_i=1 in the same cycle → all state held unchanged.
- Counter saturation: with CNT_W=4, force 17 load-use events → lu_stall_cnt_o stops at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline.
//   ctrl_t   : packed control word carried down the pipe.
//              Fields from MSB to LSB: regwrite, memread, memwrite,
//              memtoreg, alusrc, branch, jump, aluop[3:0].
//   CTRL_W   : width of ctrl_t.
//   ALUOP_*  : ALU operation encodings carried in ctrl_t.aluop.
//   XLEN_DEF / RAW_DEF : default datapath and register-address widths.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [3:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_XOR  = 4'd4;
  localparam logic [3:0] ALUOP_SLL  = 4'd5;
  localparam logic [3:0] ALUOP_SRL  = 4'd6;
  localparam logic [3:0] ALUOP_SRA  = 4'd7;
  localparam logic [3:0] ALUOP_SLT  = 4'd8;
  localparam logic [3:0] ALUOP_SLTU = 4'd9;
  localparam logic [3:0] ALUOP_LUI  = 4'd10;
  localparam logic [3:0] ALUOP_PASS = 4'd11;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the instruction in EX is a valid load to a non-zero
// register that the instruction in ID actually reads.
//   ex_valid, ex_memread, ex_rd      : state of the instruction in EX
//   id_valid, id_rs1, id_rs2         : instruction in ID
//   id_uses_rs1, id_uses_rs2         : ID really reads rs1 / rs2
//   lu                               : load-use hazard present
module load_use_detect #(
  parameter int RAW = 5
) (
  input  logic           ex_valid,
  input  logic           ex_memread,
  input  logic [RAW-1:0] ex_rd,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  input  logic           id_uses_rs1,
  input  logic           id_uses_rs2,
  output logic           lu
);

  logic rd_nonzero;
  logic src_match;

  // x0 is hard-wired to zero, so a load into it can never feed anyone.
  assign rd_nonzero = (ex_rd != '0);
  assign src_match  = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd));
  assign lu = ex_valid && ex_memread && rd_nonzero && id_valid && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Captures decoded operands and control from ID and presents them to EX.
// Inserts a bubble on flush or load-use, freezes on a global stall, and
// counts load-use bubbles in a saturating counter.
//   clk, rst            : clock, asynchronous active-high reset
//   stall_i, flush_i    : global freeze / redirect kill
//   id_*                : decoded instruction from ID
//   ex_*                : registered instruction presented to EX
//   hazard_o            : load-use hold request to PC and IF/ID
//   lu_stall_cnt_o      : saturating load-use bubble count
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [RAW-1:0]    id_rs1_i,
  input  logic [RAW-1:0]    id_rs2_i,
  input  logic [RAW-1:0]    id_rd_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [RAW-1:0]    ex_rs1_o,
  output logic [RAW-1:0]    ex_rs2_o,
  output logic [RAW-1:0]    ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  lu_stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t ex_ctrl;
  logic  lu;

  assign ex_ctrl = ctrl_t'(ex_ctrl_o);

  load_use_detect #(.RAW(RAW)) u_lud (
    .ex_valid    (ex_valid_o),
    .ex_memread  (ex_ctrl.memread),
    .ex_rd       (ex_rd_o),
    .id_valid    (id_valid_i),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .id_uses_rs1 (id_uses_rs1_i),
    .id_uses_rs2 (id_uses_rs2_i),
    .lu          (lu)
  );

  // A flush kills the ID instruction anyway, so there is nothing to hold.
  assign hazard_o = lu && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o     <= 1'b0;
      ex_pc_o        <= '0;
      ex_rs1_data_o  <= '0;
      ex_rs2_data_o  <= '0;
      ex_imm_o       <= '0;
      ex_rs1_o       <= '0;
      ex_rs2_o       <= '0;
      ex_rd_o        <= '0;
      ex_ctrl_o      <= '0;
      lu_stall_cnt_o <= '0;
    end else if (!stall_i) begin
      if (flush_i || lu) begin
        // Bubble: rd=0 and regwrite=0 keep the forwarding unit from matching.
        ex_valid_o    <= 1'b0;
        ex_pc_o       <= '0;
        ex_rs1_data_o <= '0;
        ex_rs2_data_o <= '0;
        ex_imm_o      <= '0;
        ex_rs1_o      <= '0;
        ex_rs2_o      <= '0;
        ex_rd_o       <= '0;
        ex_ctrl_o     <= '0;
        if (!flush_i && lu_stall_cnt_o != CNT_MAX)
          lu_stall_cnt_o <= lu_stall_cnt_o + 1'b1;
      end else begin
        ex_valid_o    <= id_valid_i;
        ex_pc_o       <= id_pc_i;
        ex_rs1_data_o <= id_rs1_data_i;
        ex_rs2_data_o <= id_rs2_data_i;
        ex_imm_o      <= id_imm_i;
        ex_rs1_o      <= id_rs1_i;
        ex_rs2_o      <= id_rs2_i;
        ex_rd_o       <= id_rd_i;
        // An invalid slot must never write anything downstream.
        ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // control word bit positions (MSB first: regwrite, memread, ...)
  localparam logic [CTRL_W-1:0] C_REGWRITE = 11'b100_0000_0000;
  localparam logic [CTRL_W-1:0] C_MEMREAD  = 11'b010_0000_0000;
  localparam logic [CTRL_W-1:0] C_MEMTOREG = 11'b000_1000_0000;
  localparam logic [CTRL_W-1:0] C_ALUSRC   = 11'b000_0100_0000;
  localparam logic [CTRL_W-1:0] C_LW = C_REGWRITE | C_MEMREAD | C_MEMTOREG | C_ALUSRC;
  localparam logic [CTRL_W-1:0] C_ADD = C_REGWRITE;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i, flush_i, id_valid_i;
  logic [XLEN-1:0]   id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [RAW-1:0]    id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_uses_rs1_i, id_uses_rs2_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [RAW-1:0]    ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              hazard_o;
  logic [CNT_W-1:0]  lu_stall_cnt_o;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RAW(RAW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rd_i(id_rd_i), .id_uses_rs1_i(id_uses_rs1_i),
    .id_uses_rs2_i(id_uses_rs2_i), .id_ctrl_i(id_ctrl_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o), .hazard_o(hazard_o),
    .lu_stall_cnt_o(lu_stall_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what EX should hold, described as an instruction record.
  typedef struct {
    bit              valid;
    logic [XLEN-1:0] pc, a, b, imm;
    logic [RAW-1:0]  rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  slot_t m_ex;
  int    m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.pc = '0; s.a = '0; s.b = '0; s.imm = '0;
    s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.ctrl = '0;
    return s;
  endfunction

  task automatic check_state(input string where);
    chk({where, ":valid"}, 64'(ex_valid_o), 64'(m_ex.valid));
    chk({where, ":pc"},    64'(ex_pc_o), 64'(m_ex.pc));
    chk({where, ":a"},     64'(ex_rs1_data_o), 64'(m_ex.a));
    chk({where, ":b"},     64'(ex_rs2_data_o), 64'(m_ex.b));
    chk({where, ":imm"},   64'(ex_imm_o), 64'(m_ex.imm));
    chk({where, ":rs1"},   64'(ex_rs1_o), 64'(m_ex.rs1));
    chk({where, ":rs2"},   64'(ex_rs2_o), 64'(m_ex.rs2));
    chk({where, ":rd"},    64'(ex_rd_o), 64'(m_ex.rd));
    chk({where, ":ctrl"},  64'(ex_ctrl_o), 64'(m_ex.ctrl));
    chk({where, ":cnt"},   64'(lu_stall_cnt_o), 64'(m_cnt));
  endtask

  // One clock: check the hazard request against the inputs already driven,
  // predict the next EX slot, advance the clock and compare.
  task automatic step(input string where);
    bit reads_load, lu, exp_haz;
    #1;
    reads_load = (id_uses_rs1_i && id_rs1_i == m_ex.rd) ||
                 (id_uses_rs2_i && id_rs2_i == m_ex.rd);
    lu = m_ex.valid && m_ex.ctrl[9] && (m_ex.rd != 0) && id_valid_i && reads_load;
    exp_haz = lu && !flush_i;
    chk({where, ":hazard"}, 64'(hazard_o), 64'(exp_haz));
    if (!stall_i) begin
      if (flush_i) begin
        m_ex = empty_slot();
      end else if (lu) begin
        m_ex = empty_slot();
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_ex.valid = id_valid_i;
        m_ex.pc = id_pc_i; m_ex.a = id_rs1_data_i; m_ex.b = id_rs2_data_i;
        m_ex.imm = id_imm_i; m_ex.rs1 = id_rs1_i; m_ex.rs2 = id_rs2_i;
        m_ex.rd = id_rd_i;
        m_ex.ctrl = id_valid_i ? id_ctrl_i : '0;
      end
    end
    @(posedge clk);
    #1;
    check_state(where);
  endtask

  task automatic id_instr(input logic [RAW-1:0] rd, input logic [RAW-1:0] rs1,
                          input logic [RAW-1:0] rs2, input bit u1, input bit u2,
                          input logic [CTRL_W-1:0] ctrl);
    stall_i = 0; flush_i = 0; id_valid_i = 1;
    id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
    id_imm_i = $urandom;
    id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_ctrl_i = ctrl;
  endtask

  task automatic do_reset();
    rst = 1;
    m_ex = empty_slot();
    m_cnt = 0;
    #3;
    rst = 0;
  endtask

  initial begin
    int cnt_before;
    logic [RAW-1:0] pick [3];
    pick[0] = 5'd0; pick[1] = 5'd5; pick[2] = 5'd7;
    id_instr(5'd0, 5'd0, 5'd0, 0, 0, '0);
    id_valid_i = 0;
    rst = 1;
    m_ex = empty_slot();
    m_cnt = 0;
    #22;
    check_state("reset");
    rst = 0;
    @(posedge clk); #1;

    // Normal flow: add x3,x1,x2
    id_instr(5'd3, 5'd1, 5'd2, 1, 1, C_ADD | 11'(ALUOP_ADD));
    step("add");
    chk("add:rd_is_3", 64'(ex_rd_o), 64'd3);
    chk("add:regwrite", 64'(ex_ctrl_o[10]), 64'd1);

    // Load-use: lw x5 then add x6,x5,x7
    id_instr(5'd5, 5'd1, 5'd0, 1, 0, C_LW);
    step("lw5");
    id_instr(5'd6, 5'd5, 5'd7, 1, 1, C_ADD);
    #1 chk("lu:hazard_now", 64'(hazard_o), 64'd1);
    step("lu_bubble");
    chk("lu:bubble_valid", 64'(ex_valid_o), 64'd0);
    chk("lu:cnt_one", 64'(lu_stall_cnt_o), 64'd1);
    step("lu_dep_enters");
    chk("lu:dep_rd", 64'(ex_rd_o), 64'd6);

    // No false hazard: load into x0
    id_instr(5'd0, 5'd1, 5'd0, 1, 0, C_LW);
    step("lw0");
    id_instr(5'd8, 5'd0, 5'd0, 1, 1, C_ADD);
    step("after_lw0");
    chk("x0:no_bubble", 64'(ex_valid_o), 64'd1);
    chk("x0:cnt", 64'(lu_stall_cnt_o), 64'd1);

    // No false hazard: rs2 matches but is not read
    id_instr(5'd5, 5'd1, 5'd0, 1, 0, C_LW);
    step("lw5b");
    id_instr(5'd9, 5'd1, 5'd5, 1, 0, C_ADD);
    step("rs2_unused");
    chk("rs2u:no_bubble", 64'(ex_valid_o), 64'd1);

    // Flush beats load-use: bubble, no count
    id_instr(5'd5, 5'd1, 5'd0, 1, 0, C_LW);
    step("lw5c");
    id_instr(5'd6, 5'd5, 5'd7, 1, 0, C_ADD);
    flush_i = 1;
    step("flush_lu");
    chk("flush:cnt_same", 64'(lu_stall_cnt_o), 64'd1);

    // Stall beats flush: everything held
    id_instr(5'd5, 5'd1, 5'd0, 1, 0, C_LW);
    step("lw5d");
    id_instr(5'd6, 5'd5, 5'd7, 1, 0, C_ADD);
    flush_i = 1; stall_i = 1;
    step("stall_flush");
    chk("stall:rd_held", 64'(ex_rd_o), 64'd5);

    // Async reset mid-cycle while EX holds a valid instruction
    stall_i = 0; flush_i = 0;
    chk("pre_reset:valid", 64'(ex_valid_o), 64'd1);
    #2;
    do_reset();
    check_state("async_reset");
    @(posedge clk); #1;

    // Counter saturation: 17 load-use events
    for (int i = 0; i < 17; i++) begin
      id_instr(5'd5, 5'd1, 5'd0, 1, 0, C_LW);
      step("sat_lw");
      id_instr(5'd6, 5'd5, 5'd7, 1, 0, C_ADD);
      step("sat_use");
    end
    chk("sat:cnt15", 64'(lu_stall_cnt_o), 64'd15);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
      id_imm_i = $urandom;
      id_rd_i  = pick[$urandom_range(2, 0)];
      id_rs1_i = pick[$urandom_range(2, 0)];
      id_rs2_i = pick[$urandom_range(2, 0)];
      id_uses_rs1_i = 1'($urandom);
      id_uses_rs2_i = 1'($urandom);
      id_valid_i = ($urandom_range(9, 0) < 8);
      id_ctrl_i = CTRL_W'($urandom);
      stall_i = ($urandom_range(9, 0) < 1);
      flush_i = ($urandom_range(9, 0) < 1);
      cnt_before = m_cnt;
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
